// File: rtl/gpg3_spi_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpg3_spi_cmd_arbiter
// Brief    : Round-robin arbiter that turns left/right motor DPS requests into
//            5-byte GoPiGo3 SET_MOTOR_DPS SPI frames for a byte-level engine.
// Revision : 1.0 - initial release
// ============================================================================
module gpg3_spi_cmd_arbiter #(
  parameter logic [7:0] ADDR     = 8'h08,
  parameter logic [7:0] MSG_DPS  = 8'h0E,
  parameter int         SS_SETUP = 16,
  parameter int         SS_HOLD  = 16,
  parameter int         TMO      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_l,
  input  logic [15:0] dps_l,
  input  logic        req_r,
  input  logic [15:0] dps_r,
  output logic        gnt_l,
  output logic        gnt_r,
  input  logic        busy_spi,
  output logic        start,
  output logic [7:0]  data_spi,
  output logic        SSBar,
  output logic        frame_done,
  output logic        err,
  output logic        busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] WAITB = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;
  localparam logic [2:0] GAP   = 3'd6;

  localparam logic [15:0] C_SETUP_LAST = 16'(SS_SETUP - 1);
  localparam logic [15:0] C_HOLD_LAST  = 16'(SS_HOLD - 1);
  localparam logic [15:0] C_TMO_LAST   = 16'(TMO - 1);
  localparam logic [2:0]  C_LAST_IDX   = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [1:0]  r_port;
  logic [15:0] r_dps;
  logic        r_prio_r;
  logic        r_frame_done;
  logic        r_err;

  logic        w_idle;
  logic        w_merge;
  logic        w_pick_l;
  logic        w_pick_r;
  logic        w_ss_low;
  logic [7:0]  w_byte;

  assign w_idle = (r_state == IDLE);

  // r_prio_r set means the right side is owed the next contended grant.
  assign w_merge  = req_l & req_r & (dps_l == dps_r);
  assign w_pick_l = req_l & (~req_r | ~r_prio_r);
  assign w_pick_r = req_r & (~req_l | r_prio_r);

  assign gnt_l = w_idle & ~rst & (w_merge | w_pick_l);
  assign gnt_r = w_idle & ~rst & (w_merge | w_pick_r);

  assign w_ss_low = (r_state == SETUP) | (r_state == SEND) | (r_state == WAITB) |
                    (r_state == DRAIN) | (r_state == HOLD);

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0:    w_byte = ADDR;
      3'd1:    w_byte = MSG_DPS;
      3'd2:    w_byte = {6'd0, r_port};
      3'd3:    w_byte = r_dps[15:8];
      default: w_byte = r_dps[7:0];
    endcase
  end

  assign data_spi   = ((r_state == SEND) | (r_state == WAITB)) ? w_byte : 8'h00;
  assign start      = (r_state == SEND) & ~busy_spi;
  assign SSBar      = ~w_ss_low;
  assign busy       = ~w_idle;
  assign frame_done = r_frame_done;
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 16'd0;
      r_idx        <= 3'd0;
      r_port       <= 2'd0;
      r_dps        <= 16'd0;
      r_prio_r     <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_l | req_r) begin
            r_state <= SETUP;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            // A merged frame serves both sides, so fairness state is left alone.
            if (w_merge) begin
              r_port <= 2'd3;
              r_dps  <= dps_l;
            end else if (w_pick_l) begin
              r_port   <= 2'd1;
              r_dps    <= dps_l;
              r_prio_r <= 1'b1;
            end else begin
              r_port   <= 2'd2;
              r_dps    <= dps_r;
              r_prio_r <= 1'b0;
            end
          end
        end
        SETUP: begin
          if (r_cnt == C_SETUP_LAST) begin
            r_state <= SEND;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        SEND: begin
          if (!busy_spi) begin
            r_state <= WAITB;
            r_cnt   <= 16'd0;
          end
        end
        WAITB: begin
          if (busy_spi) begin
            if (r_idx < C_LAST_IDX) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= SEND;
            end else begin
              r_state <= DRAIN;
            end
          end else if (r_cnt == C_TMO_LAST) begin
            r_state <= GAP;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (!busy_spi) begin
            r_state <= HOLD;
            r_cnt   <= 16'd0;
          end
        end
        HOLD: begin
          if (r_cnt == C_HOLD_LAST) begin
            r_state      <= GAP;
            r_frame_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        GAP: begin
          r_state <= IDLE;
          r_idx   <= 3'd0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpg3_spi_cmd_arbiter.sv
`default_nettype none
// Bench for gpg3_spi_cmd_arbiter: directed frames plus random requests scored
// against a frame-level arbitration model and an SPI engine model.
module tb_gpg3_spi_cmd_arbiter;

  localparam int         SS_SETUP = 16;
  localparam int         SS_HOLD  = 16;
  localparam int         TMO      = 255;
  localparam logic [7:0] C_ADDR   = 8'h08;
  localparam logic [7:0] C_MSG    = 8'h0E;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_l, req_r;
  logic [15:0] dps_l, dps_r;
  logic        gnt_l, gnt_r;
  logic        busy_spi;
  logic        start;
  logic [7:0]  data_spi;
  logic        SSBar;
  logic        frame_done;
  logic        err;
  logic        busy;

  gpg3_spi_cmd_arbiter #(
    .ADDR(8'h08), .MSG_DPS(8'h0E), .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_l(req_l), .dps_l(dps_l), .req_r(req_r), .dps_r(dps_r),
    .gnt_l(gnt_l), .gnt_r(gnt_r),
    .busy_spi(busy_spi), .start(start), .data_spi(data_spi),
    .SSBar(SSBar), .frame_done(frame_done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observation counters maintained by the SPI model / monitor.
  logic [7:0] byte_q[$];
  logic [7:0] q_exp[$];
  int  n_start = 0, n_done = 0, n_err = 0, n_both = 0;
  int  pre_cnt = 0, last_pre = 0, after_cnt = 0, last_after = 0;
  bit  seen_start = 0, was_low = 0;
  int  viol_busy = 0, viol_data = 0, viol_pulse = 0;
  int  spi_len = 4;
  int  spi_left = 0;
  bit  spi_dead = 0;
  bit  zero_after_gnt = 0;
  bit  m_left_next = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] port, input logic [15:0] dps);
    q_exp.push_back(C_ADDR);
    q_exp.push_back(C_MSG);
    q_exp.push_back(port);
    q_exp.push_back(dps[15:8]);
    q_exp.push_back(dps[7:0]);
  endtask

  // SPI engine model and monitor: sample mid-cycle, move busy_spi just after the edge.
  initial begin
    bit s;
    busy_spi = 1'b0;
    forever begin
      @(negedge clk);
      if (start) begin
        byte_q.push_back(data_spi);
        n_start++;
        if (!seen_start) begin
          last_pre   = pre_cnt;
          seen_start = 1;
        end
        after_cnt = 0;
      end else if (!SSBar) begin
        if (!seen_start) pre_cnt++;
        else after_cnt++;
      end
      if (SSBar) begin
        if (was_low) last_after = after_cnt;
        pre_cnt    = 0;
        after_cnt  = 0;
        seen_start = 0;
      end
      was_low = !SSBar;
      if (frame_done) n_done++;
      if (err) n_err++;
      if (gnt_l && gnt_r) n_both++;
      if (!SSBar && !busy) viol_busy++;
      if (SSBar && data_spi !== 8'h00) viol_data++;
      if ((frame_done || err) && !SSBar) viol_pulse++;
      if (start && SSBar) viol_pulse++;
      s = start;
      @(posedge clk);
      #1;
      if (spi_left > 0) begin
        spi_left--;
        if (spi_left == 0) busy_spi = 1'b0;
      end else if (s && !spi_dead) begin
        busy_spi = 1'b1;
        spi_left = spi_len;
      end
    end
  end

  task automatic run_case(input bit rl, input bit rr, input logic [15:0] dl,
                          input logic [15:0] dr, input string tag);
    int nfr, d0, e0, s0, b0, first;
    bit gl, gr, merged;
    q_exp.delete();
    merged = rl && rr && (dl == dr);
    if (merged) push_frame(8'd3, dl);
    else if (rl && rr) begin
      if (m_left_next) begin push_frame(8'd1, dl); push_frame(8'd2, dr); end
      else begin push_frame(8'd2, dr); push_frame(8'd1, dl); end
    end else if (rl) begin
      push_frame(8'd1, dl);
      m_left_next = 0;
    end else begin
      push_frame(8'd2, dr);
      m_left_next = 1;
    end
    nfr = q_exp.size() / 5;
    byte_q.delete();
    d0 = n_done; e0 = n_err; s0 = n_start; b0 = n_both; first = 0;
    @(posedge clk); #2;
    req_l = rl; req_r = rr; dps_l = dl; dps_r = dr;
    for (int c = 0; c < 4000 && (n_done + n_err) < (d0 + e0 + nfr); c++) begin
      @(negedge clk);
      gl = gnt_l; gr = gnt_r;
      if (first == 0 && (gl || gr)) first = (gl && gr) ? 3 : (gl ? 1 : 2);
      @(posedge clk); #2;
      if (gl) begin req_l = 1'b0; dps_l = zero_after_gnt ? 16'h0000 : 16'($urandom); end
      if (gr) begin req_r = 1'b0; dps_r = 16'($urandom); end
    end
    repeat (2) @(posedge clk);
    chk({tag, "_first_grant"}, first, q_exp[2]);
    chk({tag, "_nbytes"}, byte_q.size(), q_exp.size());
    for (int i = 0; i < q_exp.size() && i < byte_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), byte_q[i], q_exp[i]);
    chk({tag, "_frame_done"}, n_done - d0, nfr);
    chk({tag, "_err"}, n_err - e0, 0);
    chk({tag, "_starts"}, n_start - s0, 5 * nfr);
    chk({tag, "_same_cycle_gnt"}, n_both - b0, merged ? 1 : 0);
  endtask

  initial begin
    int d0, e0, s0, sel;
    logic [15:0] a, b;
    rst = 1'b1; req_l = 1'b1; req_r = 1'b0; dps_l = 16'h0; dps_r = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ssbar", SSBar, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_data", data_spi, 8'h00);
    chk("rst_gnt", {gnt_l, gnt_r}, 2'b00);
    chk("rst_pulses", {frame_done, err}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    req_l = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;

    spi_len = 4;
    run_case(1, 1, 16'h0064, 16'h00C8, "contend_lr");
    run_case(1, 1, 16'h01F4, 16'h01F4, "merged");
    run_case(1, 1, 16'h0100, 16'h0200, "contend_again");

    spi_len = 8;
    zero_after_gnt = 1;
    run_case(1, 0, 16'h03E8, 16'h0000, "left_only");
    zero_after_gnt = 0;
    chk("setup_len", last_pre, SS_SETUP);

    // Engine never answers: byte 0 must time out.
    spi_dead = 1;
    byte_q.delete();
    d0 = n_done; e0 = n_err;
    @(posedge clk); #2;
    req_r = 1'b1; dps_r = 16'h0BB8;
    for (int c = 0; c < 100 && !gnt_r; c++) @(negedge clk);
    @(posedge clk); #2;
    req_r = 1'b0;
    m_left_next = 1;
    for (int c = 0; c < SS_SETUP + TMO + 100 && n_err == e0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    spi_dead = 0;
    chk("tmo_err", n_err - e0, 1);
    chk("tmo_no_done", n_done - d0, 0);
    chk("tmo_wait_len", last_after, TMO);
    chk("tmo_nbytes", byte_q.size(), 1);
    chk("tmo_ssbar", SSBar, 1'b1);
    run_case(0, 1, 16'h0777, 16'h0FA0, "after_tmo");

    // Reset in the middle of byte 2 with req_l held throughout.
    spi_len = 8;
    byte_q.delete();
    d0 = n_done; e0 = n_err; s0 = n_start;
    @(posedge clk); #2;
    req_l = 1'b1; dps_l = 16'h1234;
    for (int c = 0; c < 2000 && n_start < s0 + 3; c++) @(posedge clk);
    chk("rst_mid_reached", n_start - s0, 3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ssbar", SSBar, 1'b1);
    chk("rst_mid_start", start, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_gnt", gnt_l, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    m_left_next = 1;
    req_l = 1'b0;
    run_case(1, 0, 16'h1234, 16'h0000, "regrant");
    chk("rst_mid_no_err", n_err - e0, 0);

    for (int it = 0; it < 12; it++) begin
      spi_len = $urandom_range(1, 6);
      sel = $urandom_range(0, 3);
      a = 16'($urandom);
      b = 16'($urandom);
      if (sel == 2 && a == b) b = ~a;
      case (sel)
        0: run_case(1, 0, a, b, $sformatf("rnd%0d_l", it));
        1: run_case(0, 1, a, b, $sformatf("rnd%0d_r", it));
        2: run_case(1, 1, a, b, $sformatf("rnd%0d_lr", it));
        default: run_case(1, 1, a, a, $sformatf("rnd%0d_eq", it));
      endcase
    end

    chk("inv_busy_vs_ssbar", viol_busy, 0);
    chk("inv_data_idle", viol_data, 0);
    chk("inv_pulse_ssbar", viol_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
